uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one 8-bit UART transmitter among `N_REQ` byte producers. Each producer offers a byte on a valid/ready handshake. The arbiter accepts one byte at a time, launches it with a single-cycle `tx_start` pulse, then holds off further grants until the transmitter signals frame completion. It sits between the system-side producers (command/status/debug sources) and the UART transmitter, whose `tx_start`/`tx_data`/`tx_busy` it drives and observes.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and timing defaults for the UART TX arbiter
package uart_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      WAIT_LO = 2'd2
   } arb_state_t;

   // 50 MHz / 115200 baud
   localparam int CLKS_PER_BIT    = 434;
   // One 10-bit frame plus two bit times of slack
   localparam int DEFAULT_TIMEOUT = 12 * CLKS_PER_BIT;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [IW-1:0]    last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    grant_idx,
   output logic             grant_any
);

   // Walk from last_grant+1 upward with wrap; the first valid requester wins
   always_comb begin
      int v_cand;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      v_cand    = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         v_cand = (int'(last_grant) + k) % N_REQ;
         if (!grant_any && req_valid[v_cand]) begin
            grant_any        = 1'b1;
            grant[v_cand]    = 1'b1;
            grant_idx        = IW'(v_cand);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte scheduler for one UART transmitter (optional watchdog: UART_ARB_WATCHDOG_EN)
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*DW-1:0]        req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       tx_start,
   output logic [DW-1:0]              tx_data,
   input  logic                       tx_busy,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       arb_busy,
   output logic                       timeout_err
);

   localparam int IW = $clog2(N_REQ);

   if (N_REQ < 2 || TIMEOUT < 2) begin : g_param_check
      $error("uart_tx_arbiter: N_REQ and TIMEOUT must both be at least 2");
   end

   arb_state_t         r_state;
   logic [IW-1:0]      r_last_grant;
   logic [IW-1:0]      r_grant_id;
   logic [DW-1:0]      r_tx_data;
   logic               r_tx_start;
   logic               r_timeout_err;

   logic [N_REQ-1:0]   w_grant;
   logic [IW-1:0]      w_grant_idx;
   logic               w_grant_any;
   logic               w_accept;
   logic               w_expire;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr_arbiter (
      .req_valid  (req_valid),
      .last_grant (r_last_grant),
      .grant      (w_grant),
      .grant_idx  (w_grant_idx),
      .grant_any  (w_grant_any)
   );

   // Only the winner is offered ready, and only while the transmitter is free
   assign req_ready = (r_state == IDLE) ? w_grant : '0;
   assign w_accept  = (r_state == IDLE) && w_grant_any;

`ifdef UART_ARB_WATCHDOG_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0] r_wd_cnt;

   // Watchdog: restart on every accept, count every cycle spent waiting on the transmitter
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_wd_cnt <= '0;
      else if (w_accept)
         r_wd_cnt <= '0;
      else if (r_state != IDLE)
         r_wd_cnt <= r_wd_cnt + 1'b1;
   end

   assign w_expire = (r_state != IDLE) && (r_wd_cnt == WDW'(TIMEOUT - 1));
`else
   assign w_expire = 1'b0;
`endif

   // FSM: grant in IDLE, launch, then follow tx_busy high and back low; completion beats expiry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_last_grant  <= IW'(N_REQ - 1);
         r_grant_id    <= '0;
         r_tx_data     <= '0;
         r_tx_start    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_tx_start    <= 1'b0;
         r_timeout_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_tx_data    <= req_data[int'(w_grant_idx)*DW +: DW];
                  r_grant_id   <= w_grant_idx;
                  r_last_grant <= w_grant_idx;
                  r_tx_start   <= 1'b1;
                  r_state      <= WAIT_HI;
               end
            end
            WAIT_HI: begin
               if (w_expire) begin
                  r_state       <= IDLE;
                  r_timeout_err <= 1'b1;
               end else if (tx_busy) begin
                  r_state <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (!tx_busy) begin
                  r_state <= IDLE;
               end else if (w_expire) begin
                  r_state       <= IDLE;
                  r_timeout_err <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tx_start    = r_tx_start;
   assign tx_data     = r_tx_data;
   assign grant_id    = r_grant_id;
   assign arb_busy    = (r_state != IDLE);
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a UART transmitter model
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        arb_busy;
   logic        timeout_err;

   uart_tx_arbiter #(.N_REQ(N), .DW(8), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .arb_busy    (arb_busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } sb_t;

   int checks   = 0;
   int failures = 0;

   sb_t        sb[$];
   int         order_log[$];
   logic [7:0] q0[$], q1[$], q2[$], q3[$];

   int   m_last      = 3;
   int   cyc         = 0;
   int   start_cyc   = 0;
   int   n_starts    = 0;
   int   n_timeouts  = 0;
   int   busy_len    = 10;
   int   busy_lag    = 0;
   int   tx_t        = -1;
   bit   tx_model_en = 1'b1;
   bit   prev_to     = 1'b0;
   logic [3:0] acc_mask = '0;
   int   w_model;
   sb_t  e_new;
   sb_t  e_got;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int qsize(input int id);
      case (id)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic logic [7:0] qfront(input int id);
      case (id)
         0: return q0[0];
         1: return q1[0];
         2: return q2[0];
         default: return q3[0];
      endcase
   endfunction

   task automatic qpop(input int id);
      case (id)
         0: void'(q0.pop_front());
         1: void'(q1.pop_front());
         2: void'(q2.pop_front());
         default: void'(q3.pop_front());
      endcase
   endtask

   task automatic push_req(input int id, input logic [7:0] b);
      case (id)
         0: q0.push_back(b);
         1: q1.push_back(b);
         2: q2.push_back(b);
         default: q3.push_back(b);
      endcase
   endtask

   function automatic int model_winner(input logic [3:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // Monitor, transmitter model and requesters, all on the falling edge in a fixed order
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         tx_t      = -1;
         tx_busy   = 1'b0;
         req_valid = '0;
         req_data  = '0;
         acc_mask  = '0;
         prev_to   = 1'b0;
      end else begin
         if (tx_start) begin
            n_starts++;
            chk_eq("start_lat", {31'd0, |acc_mask}, 32'd1);
            chk_eq("start_gap", {31'd0, tx_t >= 0}, 32'd0);
            chk_eq("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               e_got = sb.pop_front();
               chk_eq("tx_data", {24'd0, tx_data}, {24'd0, e_got.data});
               chk_eq("grant_id", {30'd0, grant_id}, {30'd0, e_got.id});
            end
            start_cyc = cyc;
         end
         if (timeout_err) begin
            n_timeouts++;
            chk_eq("wd_lat", cyc - start_cyc, TO);
            chk_eq("wd_pulse", {31'd0, prev_to}, 32'd0);
         end
         prev_to = timeout_err;

         if (!tx_model_en) begin
            tx_t    = -1;
            tx_busy = 1'b0;
         end else begin
            if (tx_start) tx_t = 0;
            else if (tx_t >= 0) tx_t++;
            tx_busy = (tx_t >= busy_lag) && (tx_t < busy_lag + busy_len);
            if (tx_t >= busy_lag + busy_len) tx_t = -1;
         end

         for (int i = 0; i < N; i++) if (acc_mask[i]) qpop(i);
         for (int i = 0; i < N; i++) begin
            req_valid[i]       = (qsize(i) != 0);
            req_data[i*8 +: 8] = (qsize(i) != 0) ? qfront(i) : 8'h00;
         end

         #1;
         acc_mask = req_ready & req_valid;
         if (req_ready != 4'd0) begin
            w_model = model_winner(req_valid, m_last);
            chk_eq("ready_onehot", {28'd0, req_ready}, (w_model < 0) ? 32'd0 : (32'd1 << w_model));
            chk_eq("ready_in_idle", {31'd0, arb_busy}, 32'd0);
            if (w_model >= 0) begin
               e_new.id   = 2'(w_model);
               e_new.data = qfront(w_model);
               sb.push_back(e_new);
               order_log.push_back(w_model);
               m_last = w_model;
            end
         end
      end
   end

   task automatic do_reset();
      rst    = 1'b1;
      m_last = N - 1;
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      sb.delete();
      repeat (2) @(negedge clk);
      #3;
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && q3.size() == 0 &&
               !arb_busy && !tx_busy && tx_t < 0 && sb.size() == 0) && n < budget) begin
         @(negedge clk);
         #3;
         n++;
      end
      chk_eq(tag, {31'd0, n < budget}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk_eq({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
      chk_eq({tag, "_start"}, {31'd0, tx_start}, 32'd0);
      chk_eq({tag, "_data"}, {24'd0, tx_data}, 32'd0);
      chk_eq({tag, "_gid"}, {30'd0, grant_id}, 32'd0);
      chk_eq({tag, "_busy"}, {31'd0, arb_busy}, 32'd0);
      chk_eq({tag, "_to"}, {31'd0, timeout_err}, 32'd0);
   endtask

   task automatic check_order(input string tag, input int exp[], input int n);
      chk_eq({tag, "_len"}, order_log.size(), n);
      for (int i = 0; i < n && i < order_log.size(); i++)
         chk_eq(tag, order_log[i], exp[i]);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int s0, t0, n;
      int exp2[] = '{0, 1, 2, 3, 0};
      int exp3[] = '{3, 1, 3, 1, 3, 1};
      int exp4[] = '{0, 2};

      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("rst_init");
      #2;
      rst = 1'b0;

      // Single requester, transmitter busy lagging the launch by two cycles
      busy_len = 10; busy_lag = 2;
      s0 = n_starts;
      push_req(2, 8'hA5);
      wait_idle("t1_idle", 200);
      chk_eq("t1_starts", n_starts - s0, 1);
      chk_eq("t1_gid_hold", {30'd0, grant_id}, 32'd2);
      chk_eq("t1_data_hold", {24'd0, tx_data}, 32'hA5);

      // All four requesters at once after reset
      do_reset();
      order_log.delete();
      busy_len = 5; busy_lag = 1;
      s0 = n_starts;
      push_req(0, 8'h10); push_req(1, 8'h11); push_req(2, 8'h12); push_req(3, 8'h13);
      push_req(0, 8'h14);
      wait_idle("t2_idle", 500);
      check_order("t2_order", exp2, 5);
      chk_eq("t2_starts", n_starts - s0, 5);

      // Requesters 1 and 3 contend with last grant = 1
      do_reset();
      busy_len = 3; busy_lag = 0;
      push_req(1, 8'h21);
      wait_idle("t3_pre_idle", 200);
      order_log.delete();
      for (int i = 0; i < 3; i++) begin
         push_req(1, 8'h31 + 8'(i));
         push_req(3, 8'h51 + 8'(i));
      end
      wait_idle("t3_idle", 500);
      check_order("t3_order", exp3, 6);

      // Reset while waiting for the transmitter to finish
      do_reset();
      busy_len = 30; busy_lag = 0;
      push_req(3, 8'h66);
      n = 0;
      while (!tx_busy && n < 50) begin
         @(negedge clk);
         #3;
         n++;
      end
      chk_eq("t4_busy_seen", {31'd0, n < 50}, 32'd1);
      repeat (3) @(negedge clk);
      #2;
      chk_eq("t4_arb_busy_before", {31'd0, arb_busy}, 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      do_reset();
      order_log.delete();
      push_req(0, 8'h01); push_req(2, 8'h02);
      wait_idle("t4_idle", 300);
      check_order("t4_order", exp4, 2);

      // Transmitter never asserts busy
      tx_model_en = 1'b0;
      s0 = n_starts;
      t0 = n_timeouts;
      push_req(1, 8'h77);
`ifdef UART_ARB_WATCHDOG_EN
      n = 0;
      while (n_timeouts == t0 && n < 200) begin @(negedge clk); #3; n++; end
      chk_eq("t5_to1_seen", {31'd0, n < 200}, 32'd1);
      push_req(2, 8'h78);
      n = 0;
      while (n_timeouts < t0 + 2 && n < 200) begin @(negedge clk); #3; n++; end
      chk_eq("t5_to2_seen", {31'd0, n < 200}, 32'd1);
      chk_eq("t5_starts", n_starts - s0, 2);
      chk_eq("t5_idle", {31'd0, arb_busy}, 32'd0);
      tx_model_en = 1'b1;
`else
      repeat (150) @(negedge clk);
      #3;
      chk_eq("t5_stuck", {31'd0, arb_busy}, 32'd1);
      chk_eq("t5_no_to", n_timeouts - t0, 0);
      push_req(2, 8'h78);
      repeat (20) @(negedge clk);
      #3;
      chk_eq("t5_no_grant", n_starts - s0, 1);
      tx_model_en = 1'b1;
      do_reset();
`endif

      // Busy falls on the watchdog's last cycle, then stays one cycle too long
      busy_lag = 0;
      busy_len = TO - 1;
      t0 = n_timeouts;
      push_req(0, 8'h3C);
      wait_idle("t6a_idle", 300);
      chk_eq("t6a_no_to", n_timeouts - t0, 0);
      busy_len = TO;
      t0 = n_timeouts;
      push_req(1, 8'hC3);
      wait_idle("t6b_idle", 300);
`ifdef UART_ARB_WATCHDOG_EN
      chk_eq("t6b_to", n_timeouts - t0, 1);
`else
      chk_eq("t6b_to", n_timeouts - t0, 0);
`endif

      chk_eq("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
